// File: rtl/conv3x3_stream_if.sv
// conv3x3_stream_if: pixel stream bundle for the 3x3 neighbourhood filter.
//   Input side : READY (pixel valid), POSX/POSY (pixel coordinates),
//                IN_PIX (CH channels of PW bits, channel 0 in LSBs),
//                MODE (filter select), RDEN (accept strobe back to source).
//   Output side: WREN (result valid), OUT_PIX (filtered pixel),
//                OUT_POSX/OUT_POSY (coordinates of the producing input pixel).
//   slave  modport: filter side.
//   master modport: frame reader / writer side.
interface conv3x3_stream_if #(
    parameter int PW    = 8,
    parameter int CH    = 3,
    parameter int POS_W = 12
);
    logic                READY;
    logic [POS_W-1:0]    POSX;
    logic [POS_W-1:0]    POSY;
    logic [1:0]          MODE;
    logic                RDEN;
    logic [CH*PW-1:0]    IN_PIX;
    logic                WREN;
    logic [CH*PW-1:0]    OUT_PIX;
    logic [POS_W-1:0]    OUT_POSX;
    logic [POS_W-1:0]    OUT_POSY;

    modport slave (
        input  READY, POSX, POSY, MODE, IN_PIX,
        output RDEN, WREN, OUT_PIX, OUT_POSX, OUT_POSY
    );

    modport master (
        output READY, POSX, POSY, MODE, IN_PIX,
        input  RDEN, WREN, OUT_PIX, OUT_POSX, OUT_POSY
    );
endinterface

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 neighbourhood filter, one output per accepted
// input pixel, two cycles of latency, no stalls.
//   CLK : clock
//   RST : synchronous active-high reset (wins over a simultaneous READY)
//   io  : conv3x3_stream_if.slave (READY/POSX/POSY/MODE/IN_PIX in,
//         RDEN/WREN/OUT_PIX/OUT_POSX/OUT_POSY out)
// Modes: 0 Sobel-X (clipped), 1 Sobel-Y (clipped), 2 |Gx|+|Gy| (saturated),
// 3 Gaussian blur. The result for input (x,y) is centred on (x-1,y-1); inputs
// with POSX<2 or POSY<2 give a zero pixel but still pulse WREN.
module conv3x3_stream #(
    parameter int PW    = 8,
    parameter int CH    = 3,
    parameter int IMG_W = 1920,
    parameter int IMG_H = 1080,
    parameter int POS_W = 12
) (
    input logic              CLK,
    input logic              RST,
    conv3x3_stream_if.slave  io
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int DW = CH * PW;

    typedef enum logic [1:0] {
        MODE_SOBEL_X  = 2'd0,
        MODE_SOBEL_Y  = 2'd1,
        MODE_GRAD_MAG = 2'd2,
        MODE_BLUR     = 2'd3
    } mode_e;

    if (AW > POS_W || IMG_H > (1 << POS_W) || IMG_W < 3 || IMG_H < 3) begin : g_bad_params
        $error("conv3x3_stream: POS_W too narrow for IMG_W/IMG_H, or image smaller than 3x3");
    end

    logic          accept;
    logic [AW-1:0] addr;
    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] lb0_rd;
    logic [DW-1:0] lb1_rd;

    // Window columns [0]=x-2, [1]=x-1, [2]=x; rows [0]=y-2, [1]=y-1, [2]=y.
    logic [DW-1:0]    win [3][3];
    logic             v1;
    logic [POS_W-1:0] pos1x;
    logic [POS_W-1:0] pos1y;
    mode_e            mode_q;
    logic [DW-1:0]    res;
    logic             border;

    assign io.RDEN = io.READY;
    assign accept  = io.READY && !RST;
    assign addr    = io.POSX[AW-1:0];
    assign lb0_rd  = lb0[addr];
    assign lb1_rd  = lb1[addr];

    // Line buffers: read-before-write, not cleared by reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            lb0[addr] <= io.IN_PIX;
            lb1[addr] <= lb0_rd;
        end
    end

    // Stage 1: window shift, coordinate tag, frame-start mode capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1     <= 1'b0;
            pos1x  <= '0;
            pos1y  <= '0;
            mode_q <= MODE_SOBEL_X;
            for (int unsigned k = 0; k < 3; k++) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    win[k][r] <= '0;
                end
            end
        end else begin
            v1 <= io.READY;
            if (io.READY) begin
                pos1x <= io.POSX;
                pos1y <= io.POSY;
                for (int unsigned r = 0; r < 3; r++) begin
                    win[0][r] <= win[1][r];
                    win[1][r] <= win[2][r];
                end
                win[2][0] <= lb1_rd;
                win[2][1] <= lb0_rd;
                win[2][2] <= io.IN_PIX;
                if (io.POSX == '0 && io.POSY == '0) begin
                    mode_q <= mode_e'(io.MODE);
                end
            end
        end
    end

    // Per-channel arithmetic on the stage-1 window, PW+4 bit intermediates.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [PW+3:0]        p [3][3];
        logic signed [PW+3:0] gx;
        logic signed [PW+3:0] gy;
        logic [PW+3:0]        ax;
        logic [PW+3:0]        ay;
        logic [PW+3:0]        mag;
        logic [PW+3:0]        blur_sum;
        logic [PW-1:0]        r_pix;

        always_comb begin
            for (int unsigned k = 0; k < 3; k++) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    p[k][r] = {4'b0000, win[k][r][c*PW +: PW]};
                end
            end
        end

        always_comb begin
            r_pix = '0;
            // Unsigned wrap-around subtraction reinterpreted as signed: the true
            // value always fits in PW+3 bits, so the sign bit is exact.
            gx = $signed((p[2][0] + p[2][1] + p[2][1] + p[2][2]) -
                         (p[0][0] + p[0][1] + p[0][1] + p[0][2]));
            gy = $signed((p[0][2] + p[1][2] + p[1][2] + p[2][2]) -
                         (p[0][0] + p[1][0] + p[1][0] + p[2][0]));
            ax = gx[PW+3] ? unsigned'(-gx) : unsigned'(gx);
            ay = gy[PW+3] ? unsigned'(-gy) : unsigned'(gy);
            mag = ax + ay;
            blur_sum = (p[0][0] + p[2][0] + p[0][2] + p[2][2])
                     + ((p[1][0] + p[0][1] + p[2][1] + p[1][2]) << 1)
                     + (p[1][1] << 2)
                     + (PW+4)'(8);
            case (mode_q)
                MODE_SOBEL_X: begin
                    if (gx[PW+3])           r_pix = '0;
                    else if (|gx[PW+2:PW])  r_pix = '1;
                    else                    r_pix = gx[PW-1:0];
                end
                MODE_SOBEL_Y: begin
                    if (gy[PW+3])           r_pix = '0;
                    else if (|gy[PW+2:PW])  r_pix = '1;
                    else                    r_pix = gy[PW-1:0];
                end
                MODE_GRAD_MAG: begin
                    if (|mag[PW+3:PW])      r_pix = '1;
                    else                    r_pix = mag[PW-1:0];
                end
                MODE_BLUR: begin
                    r_pix = PW'(blur_sum >> 4);
                end
                default: r_pix = '0;
            endcase
        end

        assign res[c*PW +: PW] = r_pix;
    end

    // Inputs in column 0/1 or row 0/1 have no full neighbourhood.
    assign border = (pos1x[POS_W-1:1] == '0) || (pos1y[POS_W-1:1] == '0);

    // Stage 2: registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            io.WREN     <= 1'b0;
            io.OUT_PIX  <= '0;
            io.OUT_POSX <= '0;
            io.OUT_POSY <= '0;
        end else begin
            io.WREN <= v1;
            if (v1) begin
                io.OUT_PIX  <= border ? '0 : res;
                io.OUT_POSX <= pos1x;
                io.OUT_POSY <= pos1y;
            end
        end
    end
endmodule
